// File: rtl/key_press_encoder.sv
// Button front end: 2-flop synchroniser, whole-vector debounce and a press FSM
// that latches an encoded answer code once per accepted press.
module key_press_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] raw_keys,
   output logic        key_pressed,
   output logic [15:0] user_input,
   output logic        key_event
);

   // Counter only ever reaches DEBOUNCE_CYCLES-2 before acceptance.
   localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {IDLE, PRESSED, RELEASED} state_t;

   state_t        state_q;
   logic [15:0]   sync_q1, sync_q2, prev_q;
   logic [15:0]   stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          changed, accept;
   logic [3:0]    low_idx;
   logic          multi;
   logic [15:0]   code;

   // Run length at this edge is 1 on a change, else cnt_q+2.
   always_comb begin
      changed  = (sync_q2 != prev_q);
      accept   = 1'b0;
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_q2 != stable_q) begin
         if (changed) accept = (DEBOUNCE_CYCLES == 1);
         else         accept = ((32'(cnt_q) + 32'd2) == DEBOUNCE_CYCLES);
         if (accept)        stable_d = sync_q2;
         else if (!changed) cnt_d    = cnt_q + CW'(1);
      end
   end

   always_comb begin
      low_idx = '0;
      for (int unsigned i = 16; i > 0; i--) begin
         if (stable_q[i-1]) low_idx = 4'(i - 1);
      end
      multi = |(stable_q & (stable_q - 16'd1));
      code  = {multi, 11'b0, low_idx};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q1  <= '0;
         sync_q2  <= '0;
         prev_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         sync_q1  <= raw_keys;
         sync_q2  <= sync_q1;
         prev_q   <= sync_q2;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         key_pressed <= 1'b0;
         user_input  <= '0;
         key_event   <= 1'b0;
      end else begin
         key_event <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (stable_q != '0) begin
                  state_q     <= PRESSED;
                  key_pressed <= 1'b1;
                  key_event   <= 1'b1;
                  user_input  <= code;
               end
            end
            PRESSED: begin
               if (stable_q == '0) begin
                  state_q     <= RELEASED;
                  key_pressed <= 1'b0;
               end
            end
            RELEASED: begin
               state_q <= IDLE;
            end
            default: begin
               state_q     <= IDLE;
               key_pressed <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_press_encoder.sv
// Bench for key_press_encoder: expected press/release edges are queued when
// stimulus is applied and matched against observed key_pressed transitions.
module tb_key_press_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] raw_keys = '0;
   logic        key_pressed;
   logic [15:0] user_input;
   logic        key_event;

   key_press_encoder #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_keys    (raw_keys),
      .key_pressed (key_pressed),
      .user_input  (user_input),
      .key_event   (key_event)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_fall;
      int unsigned cyc;
      logic [15:0] code;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;
   bit          in_reset = 1'b1;
   logic        prev_kp = 1'b0;
   int unsigned last_fall = 0;
   int unsigned e0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input bit is_fall, input int unsigned c, input logic [15:0] code);
      exp_t e;
      e.is_fall = is_fall;
      e.cyc     = c;
      e.code    = code;
      sb.push_back(e);
   endtask

   // Edge index: the posedge that captures a value driven now is cyc+1.
   always @(posedge clk) begin
      cyc++;
      in_reset = !rst_n;
   end

   always @(negedge clk) begin
      exp_t e;
      if (in_reset) begin
         check_eq("rst_kp", 32'(key_pressed), 32'd0);
         check_eq("rst_ui", 32'(user_input), 32'd0);
         check_eq("rst_ev", 32'(key_event), 32'd0);
         prev_kp = 1'b0;
      end else begin
         if (key_pressed && !prev_kp) begin
            if (sb.size() == 0) begin
               check_eq("spurious_rise", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               check_eq("rise_kind", 32'(e.is_fall), 32'd0);
               check_eq("rise_cycle", cyc, e.cyc);
               check_eq("rise_code", 32'(user_input), 32'(e.code));
               check_eq("rise_event", 32'(key_event), 32'd1);
               check_eq("low_gap_ge2", 32'((cyc - last_fall) >= 2), 32'd1);
            end
         end else if (!key_pressed && prev_kp) begin
            last_fall = cyc;
            if (sb.size() == 0) begin
               check_eq("spurious_fall", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               check_eq("fall_kind", 32'(e.is_fall), 32'd1);
               check_eq("fall_cycle", cyc, e.cyc);
               check_eq("fall_code_hold", 32'(user_input), 32'(e.code));
            end
            check_eq("fall_event", 32'(key_event), 32'd0);
         end else if (key_event) begin
            check_eq("stray_event", 32'(key_event), 32'd0);
         end
         prev_kp = key_pressed;
      end
   end

   initial begin
      tick(3);
      check_eq("reset_kp", 32'(key_pressed), 32'd0);
      check_eq("reset_ui", 32'(user_input), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // single press of key 2
      e0 = cyc + 1; raw_keys = 16'h0004; push(1'b0, e0 + 6, 16'h0002);
      tick(20);
      e0 = cyc + 1; raw_keys = 16'h0000; push(1'b1, e0 + 6, 16'h0002);
      tick(12);
      check_eq("single_ui_hold", 32'(user_input), 32'h0002);

      // 3-cycle glitch must not be accepted
      raw_keys = 16'h0001;
      tick(3);
      raw_keys = 16'h0000;
      tick(14);
      check_eq("glitch_kp", 32'(key_pressed), 32'd0);
      check_eq("glitch_ui", 32'(user_input), 32'h0002);

      // multi-key press, then key change while held
      e0 = cyc + 1; raw_keys = 16'h0120; push(1'b0, e0 + 6, 16'h8005);
      tick(10);
      raw_keys = 16'h0001;
      tick(10);
      check_eq("multi_ui_hold", 32'(user_input), 32'h8005);
      check_eq("multi_kp_held", 32'(key_pressed), 32'd1);
      e0 = cyc + 1; raw_keys = 16'h0000; push(1'b1, e0 + 6, 16'h8005);
      tick(12);

      // back-to-back presses
      e0 = cyc + 1; raw_keys = 16'h0002; push(1'b0, e0 + 6, 16'h0001);
      tick(10);
      e0 = cyc + 1; raw_keys = 16'h0000; push(1'b1, e0 + 6, 16'h0001);
      for (int i = 0; i < 30 && key_pressed; i++) tick(1);
      check_eq("b2b_fall_wait", 32'(key_pressed), 32'd0);
      e0 = cyc + 1; raw_keys = 16'h0001; push(1'b0, e0 + 6, 16'h0000);
      tick(10);
      check_eq("b2b_second_ui", 32'(user_input), 32'h0000);

      // bouncing release of the currently held key, then a clean press of key 3
      raw_keys = 16'h0000;
      tick(2);
      raw_keys = 16'h0001;
      tick(12);
      e0 = cyc + 1; raw_keys = 16'h0000; push(1'b1, e0 + 6, 16'h0000);
      tick(12);
      e0 = cyc + 1; raw_keys = 16'h0008; push(1'b0, e0 + 6, 16'h0003);
      tick(10);
      for (int i = 0; i < 4; i++) begin
         raw_keys = (i % 2 == 0) ? 16'h0000 : 16'h0008;
         tick(2);
      end
      e0 = cyc + 1; raw_keys = 16'h0000; push(1'b1, e0 + 6, 16'h0003);
      tick(2);
      check_eq("bounce_kp_held", 32'(key_pressed), 32'd1);
      tick(12);

      // reset asserted mid-press with the key held throughout
      e0 = cyc + 1; raw_keys = 16'h0010; push(1'b0, e0 + 6, 16'h0004);
      tick(10);
      rst_n = 1'b0;
      tick(2);
      check_eq("midrst_kp", 32'(key_pressed), 32'd0);
      check_eq("midrst_ui", 32'(user_input), 32'd0);
      rst_n = 1'b1;
      e0 = cyc + 1; push(1'b0, e0 + 6, 16'h0004);
      tick(5);
      check_eq("postrst_early_kp", 32'(key_pressed), 32'd0);
      tick(7);
      check_eq("postrst_ui", 32'(user_input), 32'h0004);
      e0 = cyc + 1; raw_keys = 16'h0000; push(1'b1, e0 + 6, 16'h0004);
      tick(12);

      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
